// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - serial TX/RX bus and backdoor preload port of mem_responder
interface mem_responder_if #(
  parameter int NSHIFT     = 2,
  parameter int LOG2_BYTES = 6
);
  logic [NSHIFT-1:0]     tx_pins;
  logic [NSHIFT-1:0]     rx_pins;
  logic                  busy;
  logic                  overflow;
  logic                  dbg_we;
  logic [LOG2_BYTES-1:0] dbg_addr;
  logic [7:0]            dbg_wdata;

  modport master (
    output tx_pins, dbg_we, dbg_addr, dbg_wdata,
    input  rx_pins, busy, overflow
  );

  modport slave (
    input  tx_pins, dbg_we, dbg_addr, dbg_wdata,
    output rx_pins, busy, overflow
  );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - memory-side responder for the 2-bit serial TX/RX bus
// Optional macro RESP_WRITE_ACK_EN: completed writes return a one-beat ack reply.
module mem_responder #(
  parameter int NSHIFT       = 2,
  parameter int LOG2_BYTES   = 6,
  parameter int READ_LATENCY = 2
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);
  localparam int         DEPTH   = 1 << LOG2_BYTES;
  localparam logic [4:0] LAT_M1  = 5'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);
  localparam logic [1:0] OP_READ = 2'b01;
  localparam logic [1:0] OP_W8   = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  typedef enum logic [2:0] {T_IDLE, T_WAIT, T_START, T_PAYLOAD, T_ACK} t_state_t;

  r_state_t r_state, r_next;
  t_state_t t_state, t_next, load_target;

  logic [NSHIFT-1:0]     tx;
  logic [1:0]            op;
  logic [3:0]            beat;
  logic [15:0]           addr_sr, data_sr, addr_full, data_full;
  logic                  addr_last, data_last, rd_cap, wr_done;
  logic [LOG2_BYTES-1:0] wa, wa_hi, ra, ra_hi;
  logic [7:0]            mem [DEPTH];
  logic [15:0]           rd_data;

  logic                  cap_valid, cap_ack, tx_free, load, load_ack, to_slot, drop;
  logic                  slot_full, slot_ack, overflow_q;
  logic [15:0]           slot_data, tshift;
  logic [4:0]            tcnt;
  logic [1:0]            pay_bits;

  assign tx        = bus.tx_pins;
  assign addr_full = {tx, addr_sr[15:2]};
  assign data_full = {tx, data_sr[15:2]};
  assign addr_last = (r_state == R_ADDR) && (beat == 4'd7);
  assign data_last = (r_state == R_DATA) && (beat == ((op == OP_W8) ? 4'd3 : 4'd7));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (tx != '0) r_next = R_ADDR;
      R_ADDR:  if (addr_last) r_next = (op == OP_READ) ? R_IDLE : R_DATA;
      R_DATA:  if (data_last) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    rd_cap  = 1'b0;
    wr_done = 1'b0;
    if (addr_last && op == OP_READ) rd_cap = 1'b1;
    if (data_last) wr_done = 1'b1;
  end

  // Address and data arrive LSB pair first, so shift in from the top.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op      <= '0;
      beat    <= '0;
      addr_sr <= '0;
      data_sr <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          op   <= tx;
          beat <= '0;
        end
        R_ADDR: begin
          addr_sr <= addr_full;
          beat    <= addr_last ? 4'd0 : beat + 4'd1;
        end
        R_DATA: begin
          data_sr <= data_full;
          beat    <= beat + 4'd1;
        end
        default: beat <= '0;
      endcase
    end
  end

  assign wa      = addr_sr[LOG2_BYTES-1:0];
  assign wa_hi   = wa + 1'b1;
  assign ra      = addr_full[LOG2_BYTES-1:0];
  assign ra_hi   = ra + 1'b1;
  assign rd_data = {mem[ra_hi], mem[ra]};

  // Bus write is issued after the backdoor write so it wins a same-byte collision.
  always_ff @(posedge clk) begin
    if (bus.dbg_we) mem[bus.dbg_addr] <= bus.dbg_wdata;
    if (wr_done) begin
      if (op == OP_W8) begin
        mem[wa] <= data_full[15:8];
      end else begin
        mem[wa]    <= data_full[7:0];
        mem[wa_hi] <= data_full[15:8];
      end
    end
  end

`ifdef RESP_WRITE_ACK_EN
  assign cap_valid = rd_cap || wr_done;
  assign cap_ack   = wr_done;
`else
  assign cap_valid = rd_cap;
  assign cap_ack   = 1'b0;
`endif

  // The transmitter can take new data on its final beat, which allows gapless replies.
  assign tx_free     = (t_state == T_IDLE) || (t_state == T_ACK) ||
                       ((t_state == T_PAYLOAD) && (tcnt == 5'd7));
  assign load        = tx_free && (slot_full || cap_valid);
  assign load_ack    = slot_full ? slot_ack : cap_ack;
  assign to_slot     = cap_valid && !slot_full && !tx_free;
  assign drop        = cap_valid && slot_full;
  assign load_target = load_ack ? T_ACK : ((READ_LATENCY == 0) ? T_START : T_WAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) t_state <= T_IDLE;
    else       t_state <= t_next;
  end

  always_comb begin
    t_next = t_state;
    case (t_state)
      T_IDLE, T_ACK: t_next = load ? load_target : T_IDLE;
      T_WAIT:        if (tcnt == 5'd0) t_next = T_START;
      T_START:       t_next = T_PAYLOAD;
      T_PAYLOAD:     if (tcnt == 5'd7) t_next = load ? load_target : T_IDLE;
      default:       t_next = T_IDLE;
    endcase
  end

  assign pay_bits = tshift[{tcnt[2:0], 1'b0} +: 2];

  always_comb begin
    bus.rx_pins = '0;
    case (t_state)
      T_START:   bus.rx_pins = 2'b01;
      T_PAYLOAD: bus.rx_pins = pay_bits;
      T_ACK:     bus.rx_pins = 2'b10;
      default:   bus.rx_pins = '0;
    endcase
    bus.busy     = (r_state != R_IDLE) || (t_state != T_IDLE) || slot_full;
    bus.overflow = overflow_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt       <= '0;
      tshift     <= '0;
      slot_full  <= 1'b0;
      slot_ack   <= 1'b0;
      slot_data  <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (load) begin
        tcnt   <= LAT_M1;
        tshift <= slot_full ? slot_data : rd_data;
      end else begin
        case (t_state)
          T_WAIT:    tcnt <= tcnt - 5'd1;
          T_START:   tcnt <= 5'd0;
          T_PAYLOAD: tcnt <= tcnt + 5'd1;
          default:   tcnt <= tcnt;
        endcase
      end
      if (load && slot_full) begin
        slot_full <= 1'b0;
      end else if (to_slot) begin
        slot_full <= 1'b1;
        slot_data <= rd_data;
        slot_ack  <= cap_ack;
      end
      if (drop) overflow_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder (latency 2 and latency 20 instances)
module tb_mem_responder;
  localparam int LB = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_responder_if #(.NSHIFT(2), .LOG2_BYTES(LB)) bus_a ();
  mem_responder_if #(.NSHIFT(2), .LOG2_BYTES(LB)) bus_b ();

  mem_responder #(.NSHIFT(2), .LOG2_BYTES(LB), .READ_LATENCY(2))
    dut_a (.clk(clk), .reset(rst), .bus(bus_a));
  mem_responder #(.NSHIFT(2), .LOG2_BYTES(LB), .READ_LATENCY(20))
    dut_b (.clk(clk), .reset(rst), .bus(bus_b));

  int checks = 0;
  int errors = 0;
  logic [7:0]  model [2][64];
  logic [15:0] exp_a [$];
  logic [15:0] exp_b [$];
  logic [1:0]  pat [12] = '{2'd0, 2'd0, 2'd1, 2'd3, 2'd3, 2'd2, 2'd3, 2'd2, 2'd3, 2'd3, 2'd2, 2'd0};

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic put_tx(int inst, logic [1:0] v);
    if (inst == 0) bus_a.tx_pins = v;
    else           bus_b.tx_pins = v;
  endtask

  task automatic put_dbg(int inst, logic we, int a, logic [7:0] v);
    if (inst == 0) begin
      bus_a.dbg_we = we; bus_a.dbg_addr = 6'(a); bus_a.dbg_wdata = v;
    end else begin
      bus_b.dbg_we = we; bus_b.dbg_addr = 6'(a); bus_b.dbg_wdata = v;
    end
  endtask

  task automatic beat(int inst, logic [1:0] v);
    put_tx(inst, v);
    @(posedge clk); #1;
  endtask

  task automatic idle(int inst, int n);
    put_tx(inst, 2'b00);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic dbg_write(int inst, int a, logic [7:0] v);
    put_tx(inst, 2'b00);
    put_dbg(inst, 1'b1, a, v);
    @(posedge clk); #1;
    put_dbg(inst, 1'b0, 0, 8'h00);
    model[inst][a] = v;
  endtask

  task automatic send_hdr_addr(int inst, logic [1:0] op, logic [15:0] a);
    beat(inst, op);
    for (int i = 0; i < 8; i++) beat(inst, a[2*i +: 2]);
  endtask

  // collide: a backdoor write of a different value hits the low byte on the final data beat
  task automatic bus_write(int inst, bit wide, logic [15:0] a, logic [15:0] d, bit collide);
    int n  = wide ? 8 : 4;
    int lo = int'(a[5:0]);
    send_hdr_addr(inst, wide ? 2'b11 : 2'b10, a);
    for (int i = 0; i < n; i++) begin
      if (collide && i == n - 1) put_dbg(inst, 1'b1, lo, ~d[7:0]);
      beat(inst, d[2*i +: 2]);
      put_dbg(inst, 1'b0, 0, 8'h00);
    end
    model[inst][lo] = d[7:0];
    if (wide) model[inst][(lo + 1) % 64] = d[15:8];
  endtask

  task automatic bus_read(int inst, logic [15:0] a, bit use_lit, logic [15:0] lit, bit push);
    int lo = int'(a[5:0]);
    logic [15:0] e;
    e = use_lit ? lit : {model[inst][(lo + 1) % 64], model[inst][lo]};
    if (push) begin
      if (inst == 0) exp_a.push_back(e);
      else           exp_b.push_back(e);
    end
    send_hdr_addr(inst, 2'b01, a);
  endtask

  // Monitor: decodes start marker + 8 payload pairs into a word and scores it.
  bit          mon_col [2];
  int          mon_idx [2];
  logic [15:0] mon_acc [2];
  logic [1:0]  mon_r;
  logic [15:0] mon_e;
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      mon_r = (k == 0) ? bus_a.rx_pins : bus_b.rx_pins;
      if (rst) begin
        mon_col[k] = 1'b0;
        mon_idx[k] = 0;
      end else if (!mon_col[k]) begin
        if (mon_r == 2'b01) begin
          mon_col[k] = 1'b1;
          mon_idx[k] = 0;
        end else if (mon_r != 2'b00) begin
          check(k == 0 ? "a_idle_rx" : "b_idle_rx", 32'(mon_r), 32'd0);
        end
      end else begin
        mon_acc[k][2*mon_idx[k] +: 2] = mon_r;
        mon_idx[k]++;
        if (mon_idx[k] == 8) begin
          mon_col[k] = 1'b0;
          if ((k == 0 ? exp_a.size() : exp_b.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_reply inst %0d: got %0h, expected none", k, mon_acc[k]);
          end else begin
            mon_e = (k == 0) ? exp_a.pop_front() : exp_b.pop_front();
            check(k == 0 ? "a_reply" : "b_reply", 32'(mon_acc[k]), 32'(mon_e));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] e;
    bus_a.tx_pins = 2'b00;
    bus_b.tx_pins = 2'b00;
    put_dbg(0, 1'b0, 0, 8'h00);
    put_dbg(1, 1'b0, 0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_a", 32'(bus_a.rx_pins), 32'd0);
    check("rst_busy_a", 32'(bus_a.busy), 32'd0);
    check("rst_ovf_a", 32'(bus_a.overflow), 32'd0);
    check("rst_rx_b", 32'(bus_b.rx_pins), 32'd0);
    check("rst_busy_b", 32'(bus_b.busy), 32'd0);
    check("rst_ovf_b", 32'(bus_b.overflow), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 64; i++) dbg_write(k, i, 8'($urandom));

    // Exact reply timing, header at cycle 0 with latency 2
    dbg_write(0, 4, 8'hEF);
    dbg_write(0, 5, 8'hBE);
    idle(0, 2);
    bus_read(0, 16'h0004, 1'b1, 16'hBEEF, 1'b1);
    put_tx(0, 2'b00);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("t1_rx_cycle", 32'(bus_a.rx_pins), 32'(pat[i]));
    end
    check("t1_busy_low", 32'(bus_a.busy), 32'd0);
    @(posedge clk); #1;

    bus_write(0, 1'b1, 16'h0010, 16'h1234, 1'b0);
    bus_read(0, 16'h0010, 1'b1, 16'h1234, 1'b1);
    idle(0, 20);

    dbg_write(0, 'h20, 8'h00);
    bus_write(0, 1'b0, 16'h0021, 16'h00A5, 1'b0);
    bus_read(0, 16'h0020, 1'b1, 16'hA500, 1'b1);
    bus_read(0, 16'h0022, 1'b0, 16'h0000, 1'b1);
    idle(0, 30);

    dbg_write(0, 'h3F, 8'h11);
    dbg_write(0, 'h00, 8'h22);
    bus_read(0, 16'hFFFF, 1'b1, 16'h2211, 1'b1);
    idle(0, 20);

    bus_write(0, 1'b0, 16'h0030, 16'h005A, 1'b1);
    bus_read(0, 16'h0030, 1'b0, 16'h0000, 1'b1);
    idle(0, 20);

    for (int n = 0; n < 40; n++) begin
      int op;
      logic [15:0] a, d;
      op = $urandom_range(0, 2);
      a  = 16'($urandom);
      d  = 16'($urandom);
      if (op == 0) begin
        bus_read(0, a, 1'b0, 16'h0000, 1'b1);
        idle(0, $urandom_range(2, 4));
      end else begin
        bus_write(0, op == 2, a, d, 1'b0);
        if ($urandom_range(0, 1) == 1) idle(0, $urandom_range(1, 3));
      end
    end
    idle(0, 40);
    check("a_queue_drained", 32'(exp_a.size()), 32'd0);
    check("a_no_overflow", 32'(bus_a.overflow), 32'd0);

    // Three back-to-back reads at latency 20: third is dropped
    bus_read(1, 16'h0001, 1'b0, 16'h0000, 1'b1);
    bus_read(1, 16'h0011, 1'b0, 16'h0000, 1'b1);
    check("b_ovf_before_third", 32'(bus_b.overflow), 32'd0);
    bus_read(1, 16'h0021, 1'b0, 16'h0000, 1'b0);
    check("b_ovf_after_third", 32'(bus_b.overflow), 32'd1);
    idle(1, 70);
    check("b_queue_drained", 32'(exp_b.size()), 32'd0);
    check("b_ovf_sticky", 32'(bus_b.overflow), 32'd1);

    // Reset during payload beat 4 (cycle 15 relative to header)
    e = {model[0][9], model[0][8]};
    bus_read(0, 16'h0008, 1'b0, 16'h0000, 1'b0);
    put_tx(0, 2'b00);
    repeat (6) @(posedge clk);
    #1;
    check("rst_pre_beat4", 32'(bus_a.rx_pins), 32'(e[7:6]));
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_rx", 32'(bus_a.rx_pins), 32'd0);
    check("rst_mid_busy", 32'(bus_a.busy), 32'd0);
    check("rst_mid_ovf_b", 32'(bus_b.overflow), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(0, 3);
    bus_read(0, 16'h0008, 1'b0, 16'h0000, 1'b1);
    idle(0, 20);
    check("post_rst_drained", 32'(exp_a.size()), 32'd0);
    check("post_rst_busy", 32'(bus_a.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side end of the serial TX/RX bus driven by the CPU's instruction scheduler.
- Receives TX command messages (header, address, optional write data) two bits per cycle, writes or reads an internal byte-addressed register memory, and returns read data as RX reply messages.
- Used as the bench/FPGA-side memory model and as the reference responder for bus bring-up.

Parameters:
NSHIFT, 2, bits per bus cycle (only 2 supported)
LOG2_BYTES, 6, log2 of memory size in bytes (64 B)
READ_LATENCY, 2, idle cycles between read capture and RX start marker (0..31)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
tx_pins  input  NSHIFT  TX bus from CPU; 2'b00 when idle
rx_pins  output  NSHIFT  RX bus to CPU; 2'b00 when idle
busy  output  1  receiver or transmitter not idle, or pending slot full
overflow  output  1  sticky: a read reply was dropped
dbg_we  input  1  backdoor byte write (bench preload)
dbg_addr  input  LOG2_BYTES  backdoor address
dbg_wdata  input  8  backdoor data

Behaviour:
- One clock; reset is asynchronous, active-high. Reset forces rx_pins=0, busy=0, overflow=0, all FSMs to IDLE, pending slot empty. Memory contents are not reset.
- TX framing, header at cycle h, tx_pins != 0:
  - Header codes: 01=READ_16, 10=WRITE_8, 11=WRITE_16.
  - Cycles h+1..h+8: 16-bit address, LSB pair first.
  - WRITE_8: data on h+9..h+12. WRITE_16: data on h+9..h+16, LSB first.
- Receiver FSM IDLE->ADDR->DATA->IDLE:
  - 4-bit beat counter. In IDLE, only a nonzero value starts a message.
  - A new header is accepted on the cycle immediately after the last beat.
- Addressing:
  - Address bits above LOG2_BYTES-1 are ignored.
  - 16-bit accesses touch bytes a (low) and a+1 (high), wrapping mod 2^LOG2_BYTES.
- Writes:
  - Memory updated at the clock edge ending the last data beat.
  - A dbg_we write on the same edge to the same byte loses to the bus write.
- Reads:
  - Data is captured from memory at the edge ending address beat h+8, so a preceding write to the same address is visible.
- Capture routing:
  - If the transmitter is idle, the data loads into it.
  - Otherwise, if the pending slot is empty, the data goes to the slot.
  - Otherwise the reply is dropped and overflow is set (cleared only by reset).
- Transmitter FSM IDLE->WAIT (READ_LATENCY cycles)->START->PAYLOAD (8 beats)->IDLE:
  - START drives rx_pins=2'b01; PAYLOAD drives the data LSB pair first.
  - Start marker appears at capture_cycle+1+READ_LATENCY.
  - Pending-slot data loads into the transmitter at the end of the last payload beat and follows the same timing, with capture_cycle = last payload cycle.
  - Gapless back-to-back replies are possible with READ_LATENCY=0.
- Receiver and transmitter run concurrently.
- Reset asserted mid-message aborts both; rx_pins returns to 0 immediately (asynchronously).

Optional Feature:
- Macro: RESP_WRITE_ACK_EN.
- When defined, each completed write queues an ack reply: rx_pins=2'b10 for one cycle, no payload, no latency wait.
  - Ack replies share the transmitter and pending slot with read replies, including overflow rules.
- When undefined, writes produce no RX traffic.

Test Plan:
- Preload bytes 0x04=0xEF, 0x05=0xBE; READ_16 to 0x0004 with header at cycle 0, L=2 -> rx_pins=01 at cycle 11, then pairs 3,3,2,3,2,3,3,2 on cycles 12..19; busy low at 20.
- WRITE_16 0x1234 to 0x0010, then READ_16 0x0010 back-to-back -> reply payload 0x1234.
- WRITE_8 0xA5 to 0x0021, then READ_16 0x0020 with byte 0x20 preloaded to 0x00 -> reply 0xA500; byte 0x22 unchanged.
- READ_16 at 0xFFFF (LOG2_BYTES=6) with byte 0x3F=0x11, byte 0x00=0x22 -> reply 0x2211.
- READ_LATENCY=20, three back-to-back READ_16 -> two replies, overflow=1 after the third capture (cycle 26 edge).
- Reset pulse during payload beat 4 of a reply -> rx_pins=0 immediately, busy=0; a subsequent READ_16 is answered normally.
